// File: rtl/layer_sequencer_pkg.sv
// Purpose: shared types and constants for the layer sequencer, RAM controller and datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package layer_sequencer_pkg;

  // Default network geometry shared with the RAM controller and summation datapath
  localparam int NN_NUM_LAYERS  = 3;
  localparam int NN_NUM_OUTPUTS = 4;
  localparam int NN_TIMEOUT     = 1023;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_WAIT_RAM = 4'd2,
    ST_SUM      = 4'd3,
    ST_WAIT_SUM = 4'd4,
    ST_NEXT     = 4'd5,
    ST_SCAN     = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } seq_state_e;

  // Index width for a count of n items, never narrower than one bit
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Purpose: control/handshake bundle between host/datapath (master) and the layer sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: none; RAM_done/done are single-cycle completion strobes.
interface layer_sequencer_if #(
  parameter int LAYER_W = 2,
  parameter int OUT_W   = 2
);
  logic               start;
  logic               continuous;
  logic               abort;
  logic               RAM_done;
  logic               done;
  logic               RAM_Controll_Start;
  logic               sum_trigger;
  logic [LAYER_W-1:0] layer_sel;
  logic [OUT_W-1:0]   output_sel;
  logic               out_valid;
  logic               busy;
  logic               net_done;
  logic               error;

  modport master (
    output start, continuous, abort, RAM_done, done,
    input  RAM_Controll_Start, sum_trigger, layer_sel, output_sel,
           out_valid, busy, net_done, error
  );

  modport slave (
    input  start, continuous, abort, RAM_done, done,
    output RAM_Controll_Start, sum_trigger, layer_sel, output_sel,
           out_valid, busy, net_done, error
  );
endinterface

// File: rtl/layer_sequencer_wait_timer.sv
// Purpose: watchdog counter; flags expiry after TIMEOUT consecutive enabled cycles (0 = never).
// Latency: expired is combinational from the count, asserted in the TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module wait_timer
  import layer_sequencer_pkg::*;
#(
  parameter int TIMEOUT = NN_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int               CNT_W    = clog2w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               WD_ON    = (TIMEOUT > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = WD_ON && enable && (cnt_q == CNT_LAST);

  // Count enabled cycles, parking at the last value so the counter never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (WD_ON && enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Purpose: sequences RAM load / summation per layer, then scans all outputs; continuous, abort, watchdog.
// Latency: outputs registered; start->RAM_Controll_Start 1 cycle, minimum pass 5*NUM_LAYERS+NUM_OUTPUTS+2 cycles.
// Backpressure: holds in WAIT_RAM/WAIT_SUM until RAM_done/done, or until the watchdog sends it to ERR.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS  = NN_NUM_LAYERS,
  parameter int NUM_OUTPUTS = NN_NUM_OUTPUTS,
  parameter int TIMEOUT     = NN_TIMEOUT,
  parameter int LAYER_W     = clog2w(NUM_LAYERS),
  parameter int OUT_W       = clog2w(NUM_OUTPUTS)
) (
  input logic              clk,
  input logic              reset,
  layer_sequencer_if.slave bus
);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [OUT_W-1:0]   OUT_LAST   = OUT_W'(NUM_OUTPUTS - 1);

  seq_state_e         state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [OUT_W-1:0]   osel_q, osel_d;
  logic               error_q, error_d;
  logic               ram_start_q, ram_start_d;
  logic               sum_trig_q, sum_trig_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               net_done_q, net_done_d;

  logic in_wait;
  logic wd_expired;

  // Watchdog runs only while parked in a wait state; any other state re-arms it
  assign in_wait = (state_q == ST_WAIT_RAM) || (state_q == ST_WAIT_SUM);

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(wd_expired)
  );

  // Next-state, counter and sticky-error logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    osel_d  = osel_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        layer_d = '0;
        osel_d  = '0;
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_WAIT_RAM;
      ST_WAIT_RAM: begin
        if (bus.RAM_done) begin
          state_d = ST_SUM;
        end else if (wd_expired) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          layer_d = '0;
          osel_d  = '0;
        end
      end
      ST_SUM: state_d = ST_WAIT_SUM;
      ST_WAIT_SUM: begin
        if (bus.done) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          layer_d = '0;
          osel_d  = '0;
        end
      end
      ST_NEXT: begin
        if (layer_q == LAYER_LAST) begin
          state_d = ST_SCAN;
          osel_d  = '0;
        end else begin
          state_d = ST_LOAD;
          layer_d = layer_q + LAYER_W'(1);
        end
      end
      ST_SCAN: begin
        if (osel_q == OUT_LAST) begin
          state_d = ST_DONE;
        end else begin
          osel_d = osel_q + OUT_W'(1);
        end
      end
      ST_DONE: begin
        layer_d = '0;
        osel_d  = '0;
        state_d = bus.continuous ? ST_LOAD : ST_IDLE;
      end
      ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          error_d = 1'b0;
          layer_d = '0;
          osel_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        layer_d = '0;
        osel_d  = '0;
      end
    endcase
    if (bus.abort) begin
      state_d = ST_IDLE;
      layer_d = '0;
      osel_d  = '0;
      error_d = error_q;
    end
  end

  // Decode strobes from the next state so they register in the cycle the state is held
  always_comb begin
    ram_start_d = (state_d == ST_LOAD);
    sum_trig_d  = (state_d == ST_SUM);
    out_valid_d = (state_d == ST_SCAN);
    net_done_d  = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, sticky error and registered output strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      layer_q     <= '0;
      osel_q      <= '0;
      error_q     <= 1'b0;
      ram_start_q <= 1'b0;
      sum_trig_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      net_done_q  <= 1'b0;
    end else begin
      layer_q     <= layer_d;
      osel_q      <= osel_d;
      error_q     <= error_d;
      ram_start_q <= ram_start_d;
      sum_trig_q  <= sum_trig_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      net_done_q  <= net_done_d;
    end
  end

  assign bus.RAM_Controll_Start = ram_start_q;
  assign bus.sum_trigger        = sum_trig_q;
  assign bus.layer_sel          = layer_q;
  assign bus.output_sel         = osel_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.busy               = busy_q;
  assign bus.net_done           = net_done_q;
  assign bus.error              = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose: scoreboard bench for layer_sequencer (3 layers, 4 outputs, TIMEOUT 8).
// Latency: expects net_done 20 cycles after the cycle start is driven (21 cycles inclusive).
// Backpressure: auto-responders answer each request one cycle later; manual pulses for corner cases.
module tb_layer_sequencer;
  localparam int NL   = 3;
  localparam int NO   = 4;
  localparam int TO   = 8;
  localparam int PASS = 5 * NL + NO + 1;

  logic clk;
  logic reset;
  logic ram_auto, sum_auto;
  logic ram_auto_p, sum_auto_p;
  logic ram_man, sum_man;
  int   cyc;
  int   n_cmp, n_bad;
  int   exp_load[$];
  int   exp_scan[$];
  int   exp_done[$];
  int   e_load, e_scan, e_done;

  layer_sequencer_if #(.LAYER_W(2), .OUT_W(2)) dif ();

  layer_sequencer #(
    .NUM_LAYERS (NL),
    .NUM_OUTPUTS(NO),
    .TIMEOUT    (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  assign dif.RAM_done = ram_auto_p | ram_man;
  assign dif.done     = sum_auto_p | sum_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rcs"},   32'(dif.RAM_Controll_Start), 32'(0));
    chk({tag, "_sumtr"}, 32'(dif.sum_trigger), 32'(0));
    chk({tag, "_layer"}, 32'(dif.layer_sel), 32'(0));
    chk({tag, "_osel"},  32'(dif.output_sel), 32'(0));
    chk({tag, "_oval"},  32'(dif.out_valid), 32'(0));
    chk({tag, "_busy"},  32'(dif.busy), 32'(0));
    chk({tag, "_ndone"}, 32'(dif.net_done), 32'(0));
    chk({tag, "_err"},   32'(dif.error), 32'(0));
  endtask

  // Queue the full expected event stream for n back-to-back passes starting at cycle c0
  task automatic push_passes(input int n, input int c0);
    for (int p = 0; p < n; p++) begin
      for (int l = 0; l < NL; l++) exp_load.push_back(l);
      for (int o = 0; o < NO; o++) exp_scan.push_back(o);
      exp_done.push_back(c0 + PASS * (p + 1));
    end
  endtask

  task automatic run_pass(input int n, input bit cont);
    int c0;
    c0 = cyc;
    dif.continuous = cont;
    push_passes(n, c0);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    chk("start_rcs", 32'(dif.RAM_Controll_Start), 32'(1));
    chk("start_err_clr", 32'(dif.error), 32'(0));
    tick();
    chk("rcs_one_cycle", 32'(dif.RAM_Controll_Start), 32'(0));
    for (int i = 0; i < 300; i++) begin
      if (cont && cyc >= c0 + PASS + 5) dif.continuous = 1'b0;
      if (exp_done.size() == 0) break;
      tick();
    end
    chk("pass_drain", 32'(exp_done.size()), 32'(0));
    dif.continuous = 1'b0;
    tick();
    tick();
    chk("pass_idle_busy", 32'(dif.busy), 32'(0));
  endtask

  // RAM responder: RAM_done one cycle after each load request
  initial begin
    ram_auto_p = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_auto && dif.RAM_Controll_Start) begin
        @(negedge clk);
        ram_auto_p = 1'b1;
        @(negedge clk);
        ram_auto_p = 1'b0;
      end
    end
  end

  // Summation responder: done one cycle after each trigger
  initial begin
    sum_auto_p = 1'b0;
    forever begin
      @(negedge clk);
      if (sum_auto && dif.sum_trigger) begin
        @(negedge clk);
        sum_auto_p = 1'b1;
        @(negedge clk);
        sum_auto_p = 1'b0;
      end
    end
  end

  // Scoreboard: pop and compare whenever the DUT produces an event
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (dif.RAM_Controll_Start) begin
        chk("load_expected", 32'(exp_load.size() != 0), 32'(1));
        if (exp_load.size() != 0) begin
          e_load = exp_load.pop_front();
          chk("load_layer", 32'(dif.layer_sel), 32'(e_load));
        end
      end
      if (dif.out_valid) begin
        chk("scan_expected", 32'(exp_scan.size() != 0), 32'(1));
        if (exp_scan.size() != 0) begin
          e_scan = exp_scan.pop_front();
          chk("scan_sel", 32'(dif.output_sel), 32'(e_scan));
        end
      end
      if (dif.net_done) begin
        chk("done_expected", 32'(exp_done.size() != 0), 32'(1));
        if (exp_done.size() != 0) begin
          e_done = exp_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e_done));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int c0;
    bit found;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    reset = 1'b0;
    ram_auto = 1'b0;
    sum_auto = 1'b0;
    ram_man = 1'b0;
    sum_man = 1'b0;
    dif.start = 1'b0;
    dif.continuous = 1'b0;
    dif.abort = 1'b0;
    repeat (3) tick();
    chk_quiet("reset");
    reset = 1'b1;
    tick();

    // Plain pass with one-cycle handshakes
    ram_auto = 1'b1;
    sum_auto = 1'b1;
    run_pass(1, 1'b0);

    // Two passes in continuous mode
    run_pass(2, 1'b1);

    // Stray handshakes ignored, then reset mid-WAIT_SUM
    ram_auto = 1'b0;
    sum_auto = 1'b0;
    exp_load.push_back(0);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    chk("ign_rcs", 32'(dif.RAM_Controll_Start), 32'(1));
    tick();
    sum_man = 1'b1;
    tick();
    sum_man = 1'b0;
    chk("ign_done_sumtr", 32'(dif.sum_trigger), 32'(0));
    chk("ign_done_busy", 32'(dif.busy), 32'(1));
    chk("ign_done_rcs", 32'(dif.RAM_Controll_Start), 32'(0));
    ram_man = 1'b1;
    tick();
    chk("sum_after_ramdone", 32'(dif.sum_trigger), 32'(1));
    tick();
    ram_man = 1'b0;
    chk("sum_one_cycle", 32'(dif.sum_trigger), 32'(0));
    tick();
    tick();
    chk("hold_wait_busy", 32'(dif.busy), 32'(1));
    chk("hold_wait_rcs", 32'(dif.RAM_Controll_Start), 32'(0));
    chk("hold_wait_layer", 32'(dif.layer_sel), 32'(0));
    exp_load.push_back(1);
    sum_man = 1'b1;
    tick();
    sum_man = 1'b0;
    tick();
    chk("next_load_rcs", 32'(dif.RAM_Controll_Start), 32'(1));
    tick();
    ram_man = 1'b1;
    tick();
    ram_man = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk_quiet("rst_mid");
    tick();
    chk("rst_mid_busy2", 32'(dif.busy), 32'(0));
    reset = 1'b1;
    tick();
    ram_auto = 1'b1;
    sum_auto = 1'b1;
    run_pass(1, 1'b0);

    // Watchdog: RAM never answers
    ram_auto = 1'b0;
    exp_load.push_back(0);
    c0 = cyc;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (TO) tick();
    chk("wd_pre_cycle", 32'(cyc), 32'(c0 + TO + 1));
    chk("wd_pre_busy", 32'(dif.busy), 32'(1));
    chk("wd_pre_err", 32'(dif.error), 32'(0));
    tick();
    chk("wd_err", 32'(dif.error), 32'(1));
    chk("wd_busy", 32'(dif.busy), 32'(0));
    chk("wd_rcs", 32'(dif.RAM_Controll_Start), 32'(0));
    tick();
    chk("wd_err_sticky", 32'(dif.error), 32'(1));
    ram_auto = 1'b1;
    run_pass(1, 1'b0);

    // Abort during output scan at output_sel 2
    for (int l = 0; l < NL; l++) exp_load.push_back(l);
    for (int o = 0; o < 3; o++) exp_scan.push_back(o);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dif.out_valid && dif.output_sel == 2'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach_scan2", 32'(found), 32'(1));
    dif.abort = 1'b1;
    tick();
    dif.abort = 1'b0;
    chk("abort_oval", 32'(dif.out_valid), 32'(0));
    chk("abort_busy", 32'(dif.busy), 32'(0));
    chk("abort_ndone", 32'(dif.net_done), 32'(0));
    chk("abort_osel", 32'(dif.output_sel), 32'(0));
    repeat (25) tick();

    chk("end_load_q", 32'(exp_load.size()), 32'(0));
    chk("end_scan_q", 32'(exp_scan.size()), 32'(0));
    chk("end_done_q", 32'(exp_done.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
